// File: rtl/jk_seq_pkg.sv
// Shared encodings for the JK bank sequencer: command opcodes and FSM states.
package jk_seq_pkg;

   localparam logic [1:0] OP_LOAD  = 2'd0;
   localparam logic [1:0] OP_CLEAR = 2'd1;
   localparam logic [1:0] OP_COUNT = 2'd2;
   localparam logic [1:0] OP_SHIFT = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/jk_cell.sv
// One JK flip-flop with asynchronous active-low preset and clear.
// Preset has priority over clear. JK: 00 hold, 01 reset, 10 set, 11 toggle.
module jk_cell (
   input  logic clk_i,
   input  logic pre_n_i,
   input  logic clr_n_i,
   input  logic j_i,
   input  logic k_i,
   output logic q_o
);

   logic q_q;

   // JK storage element with async preset/clear
   always_ff @(posedge clk_i or negedge pre_n_i or negedge clr_n_i) begin
      if (!pre_n_i) begin
         q_q <= 1'b1;
      end else if (!clr_n_i) begin
         q_q <= 1'b0;
      end else begin
         case ({j_i, k_i})
            2'b01:   q_q <= 1'b0;
            2'b10:   q_q <= 1'b1;
            2'b11:   q_q <= ~q_q;
            default: q_q <= q_q;
         endcase
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/jk_bank_seq.sv
// Sequencer for a bank of JK cells. Accepts LOAD/CLEAR/COUNT/SHIFT commands
// and drives the per-bit J/K inputs one step per unheld RUN cycle.
//
// Handshake: a command transfers at a rising clk edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE; cmd_valid is
// ignored in every other state, and the offered fields only matter on the
// transfer edge.
module jk_bank_seq
   import jk_seq_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             preset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             hold,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             done,
   output logic             wrap,
   output logic [1:0]       dbg_state
);

   state_t             state_q;
   logic [1:0]         op_q;
   logic [WIDTH-1:0]   data_q;
   logic [LEN_W-1:0]   rem_q;
   logic               ready_q;
   logic               busy_q;
   logic               done_q;
   logic               wrap_q;

   logic [LEN_W-1:0]   acc_len;
   logic               step_en;
   logic [WIDTH-1:0]   bank_q;
   logic [WIDTH-1:0]   toggle_en;
   logic [WIDTH-1:0]   shift_nx;
   logic [WIDTH-1:0]   j_d;
   logic [WIDTH-1:0]   k_d;

   // Step count taken at accept: single-shot ops always run exactly one step
   always_comb begin
      acc_len = cmd_len;
      if (cmd_op == OP_LOAD || cmd_op == OP_CLEAR) begin
         acc_len = {{(LEN_W-1){1'b0}}, 1'b1};
      end
   end

   assign step_en = (state_q == RUN) && !hold;

   // Per-bit J/K for the current step; zero (bank holds) unless stepping
   always_comb begin
      j_d          = '0;
      k_d          = '0;
      toggle_en    = '0;
      toggle_en[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         toggle_en[i] = toggle_en[i-1] & bank_q[i-1];
      end
      shift_nx = {bank_q[WIDTH-2:0], data_q[0]};
      if (step_en) begin
         case (op_q)
            OP_LOAD: begin
               j_d = data_q;
               k_d = ~data_q;
            end
            OP_CLEAR: begin
               j_d = '0;
               k_d = '1;
            end
            OP_COUNT: begin
               j_d = toggle_en;
               k_d = toggle_en;
            end
            default: begin
               j_d = shift_nx;
               k_d = ~shift_nx;
            end
         endcase
      end
   end

   // Control FSM: latches the command, counts steps, registers status outputs
   always_ff @(posedge clk or negedge preset) begin
      if (!preset) begin
         state_q <= IDLE;
         op_q    <= OP_LOAD;
         data_q  <= '0;
         rem_q   <= '0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         wrap_q <= step_en && (op_q == OP_COUNT) && (&bank_q);
         case (state_q)
            IDLE: begin
               if (cmd_valid && ready_q) begin
                  op_q    <= cmd_op;
                  data_q  <= cmd_data;
                  rem_q   <= acc_len;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  if (acc_len != '0) begin
                     state_q <= RUN;
                  end else begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (!hold) begin
                  rem_q <= rem_q - 1'b1;
                  if (rem_q == {{(LEN_W-1){1'b0}}, 1'b1}) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   // The JK bank itself; clears are unused so they are tied inactive
   for (genvar g = 0; g < WIDTH; g++) begin : g_cell
      jk_cell u_cell (
         .clk_i   (clk),
         .pre_n_i (preset),
         .clr_n_i (1'b1),
         .j_i     (j_d[g]),
         .k_i     (k_d[g]),
         .q_o     (bank_q[g])
      );
   end

   assign q         = bank_q;
   assign cmd_ready = ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign wrap      = wrap_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_jk_bank_seq.sv
// Bench for jk_bank_seq: directed scenarios followed by random commands,
// checked by a scoreboard against a plain arithmetic model of the bank.
module tb_jk_bank_seq;

  localparam int WIDTH = 4;
  localparam int LEN_W = 4;
  localparam int MODV  = 1 << WIDTH;

  localparam logic [1:0] T_LOAD  = 2'd0;
  localparam logic [1:0] T_CLEAR = 2'd1;
  localparam logic [1:0] T_COUNT = 2'd2;
  localparam logic [1:0] T_SHIFT = 2'd3;

  logic             clk = 1'b0;
  logic             preset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = '0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             hold = 1'b0;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             wrap;
  logic [1:0]       dbg_state;

  jk_bank_seq #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .preset    (preset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .hold      (hold),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap),
    .dbg_state (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  // scoreboard queues: final q, wrap pulses, edges from accept to done
  logic [WIDTH-1:0] exp_q[$];
  int               exp_wrap_q[$];
  int               exp_lat_q[$];

  int model_q = MODV - 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: pops one expectation per done pulse
  int   accept_cyc = 0;
  int   wrap_cnt = 0;
  int   done_seen = 0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    if (preset) begin
      if (wrap) wrap_cnt++;
      if (done) begin
        done_seen++;
        check("done_single_cycle", 32'(prev_done), 32'(0));
        check("busy_at_done", 32'(busy), 32'(1));
        check("ready_at_done", 32'(cmd_ready), 32'(0));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done with no pending command (t=%0t)", $time);
        end else begin
          logic [WIDTH-1:0] e;
          int ew;
          int el;
          e  = exp_q.pop_front();
          ew = exp_wrap_q.pop_front();
          el = exp_lat_q.pop_front();
          check("final_q", 32'(q), 32'(e));
          check("wrap_count", 32'(wrap_cnt), 32'(ew));
          check("latency", 32'(cyc - accept_cyc), 32'(el));
        end
      end
      if (cmd_valid && cmd_ready) begin
        accept_cyc = cyc + 1;
        wrap_cnt   = 0;
      end
    end
    prev_done = done;
  end

  // driver tasks
  task automatic wait_ready();
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!cmd_ready && n < 200);
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL wait_ready_timeout: got cmd_ready=0 expected 1 within 200 cycles");
    end
  endtask

  // hold_mode: 0 never, 1 first RUN cycle only, 2 random
  task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] data,
                       input int len, input int hold_mode);
    int steps;
    int wraps;
    int unheld;
    bit pat[$];
    steps = (op == T_LOAD || op == T_CLEAR) ? 1 : len;
    wraps = 0;
    for (int s = 0; s < steps; s++) begin
      case (op)
        T_LOAD:  model_q = int'(data);
        T_CLEAR: model_q = 0;
        T_COUNT: begin
          model_q = (model_q + 1) % MODV;
          if (model_q == 0) wraps++;
        end
        default: model_q = (model_q * 2 + int'(data) % 2) % MODV;
      endcase
    end
    unheld = 0;
    while (unheld < steps) begin
      bit h;
      if (hold_mode == 1) h = (pat.size() == 0);
      else if (hold_mode == 2) h = ($urandom_range(0, 3) == 0);
      else h = 1'b0;
      pat.push_back(h);
      if (!h) unheld++;
    end
    exp_q.push_back(WIDTH'(model_q));
    exp_wrap_q.push_back(wraps);
    exp_lat_q.push_back(pat.size());

    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_len   = LEN_W'(len);
    @(posedge clk);
    #1;
    for (int i = 0; i < pat.size(); i++) begin
      hold      = pat[i];
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 2'($urandom);
      cmd_data  = WIDTH'($urandom);
      cmd_len   = LEN_W'($urandom);
      @(posedge clk);
      #1;
    end
    // DONE cycle: offered commands and hold must both be ignored
    hold      = 1'($urandom_range(0, 1));
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_op    = 2'($urandom);
    cmd_data  = WIDTH'($urandom);
    @(posedge clk);
    #1;
    hold      = 1'b0;
    cmd_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // main sequence
  initial begin
    int ds;
    // async preset mid-cycle
    #2 preset = 1'b0;
    #1;
    check("reset_q_async", 32'(q), 32'hF);
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_ready", 32'(cmd_ready), 32'(1));
    @(negedge clk);
    preset = 1'b1;
    @(negedge clk);
    check("post_reset_ready", 32'(cmd_ready), 32'(1));
    check("post_reset_busy", 32'(busy), 32'(0));
    check("post_reset_done", 32'(done), 32'(0));
    check("post_reset_wrap", 32'(wrap), 32'(0));

    // directed scenarios
    issue(T_LOAD, 4'h5, 0, 0);
    issue(T_LOAD, 4'hE, 0, 0);
    issue(T_COUNT, 4'h0, 3, 0);
    issue(T_LOAD, 4'h5, 0, 0);
    issue(T_SHIFT, 4'h1, 2, 0);
    issue(T_CLEAR, 4'hA, 9, 0);
    issue(T_COUNT, 4'h0, 2, 1);
    issue(T_COUNT, 4'h0, 0, 0);

    // reset in the middle of an 8-step COUNT, 3 steps in
    wait_ready();
    ds = done_seen;
    cmd_valid = 1'b1;
    cmd_op    = T_COUNT;
    cmd_data  = '0;
    cmd_len   = LEN_W'(8);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_mid_q", 32'(q), 32'((model_q + 3) % MODV));
    #1 preset = 1'b0;
    #1;
    check("abort_q_async", 32'(q), 32'hF);
    check("abort_busy", 32'(busy), 32'(0));
    #1 preset = 1'b1;
    model_q = MODV - 1;
    repeat (3) @(negedge clk);
    check("abort_ready", 32'(cmd_ready), 32'(1));
    check("abort_state_idle", 32'(dbg_state), 32'(0));
    check("abort_no_done", 32'(done_seen), 32'(ds));

    // random traffic
    repeat (40) begin
      issue(2'($urandom_range(0, 3)), WIDTH'($urandom), $urandom_range(0, 15),
            $urandom_range(0, 2));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
